// File: rtl/i2c_bus_arbiter.sv
// ============================================================================
// i2c_bus_arbiter: round-robin share of one i2c byte engine between two
// requesters, with per-transaction watchdog and enforced bus-free gap. Rev 1.0
// ============================================================================
`default_nettype none

module i2c_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 2500000,
  parameter int unsigned GAP_CYCLES     = 500,
  parameter int unsigned CNT_W          = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0,
  input  logic        i_rw0,
  input  logic [7:0]  i_opcode0,
  output logic        o_gnt0,
  output logic        o_done0,
  input  logic        i_req1,
  input  logic        i_rw1,
  input  logic [7:0]  i_opcode1,
  output logic        o_gnt1,
  output logic        o_done1,
  output logic [15:0] o_rdata,
  output logic        o_timeout,
  output logic        o_start,
  output logic        o_rw,
  output logic [7:0]  o_opcode,
  input  logic        i_busy,
  input  logic        i_tick_done,
  input  logic [15:0] i_data
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             gnt0, gnt0_n, gnt1, gnt1_n;
  logic             start, start_n, rw, rw_n;
  logic [7:0]       opcode, opcode_n;
  logic             done0, done0_n, done1, done1_n;
  logic             timeout, timeout_n;
  logic [15:0]      rdata, rdata_n;
  logic             last, last_n;
  logic             pick1;
  logic             complete;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    gnt0_n    = gnt0;
    gnt1_n    = gnt1;
    start_n   = start;
    rw_n      = rw;
    opcode_n  = opcode;
    done0_n   = 1'b0;
    done1_n   = 1'b0;
    timeout_n = 1'b0;
    rdata_n   = rdata;
    last_n    = last;
    pick1     = 1'b0;
    complete  = 1'b0;

    case (state)
      IDLE: begin
        if (i_req0 || i_req1) begin
          // last=1 means requester 1 was served most recently, so 0 wins a tie
          pick1    = i_req1 && (!i_req0 || !last);
          gnt0_n   = !pick1;
          gnt1_n   = pick1;
          start_n  = 1'b1;
          rw_n     = pick1 ? i_rw1 : i_rw0;
          opcode_n = pick1 ? i_opcode1 : i_opcode0;
          cnt_n    = '0;
          state_n  = LAUNCH;
        end
      end
      LAUNCH, WAIT: begin
        if (i_tick_done) begin
          complete = 1'b1;
          if (rw) rdata_n = i_data;
        end else if (cnt == TIMEOUT_LAST) begin
          complete  = 1'b1;
          timeout_n = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
          if (state == LAUNCH && i_busy) begin
            start_n = 1'b0;
            state_n = WAIT;
          end
        end
        if (complete) begin
          done0_n = gnt0;
          done1_n = gnt1;
          last_n  = gnt1;
          gnt0_n  = 1'b0;
          gnt1_n  = 1'b0;
          start_n = 1'b0;
          cnt_n   = '0;
          state_n = GAP;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) state_n = IDLE;
        else                 cnt_n   = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      start   <= 1'b0;
      rw      <= 1'b0;
      opcode  <= 8'h00;
      done0   <= 1'b0;
      done1   <= 1'b0;
      timeout <= 1'b0;
      rdata   <= 16'h0000;
      last    <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      gnt0    <= gnt0_n;
      gnt1    <= gnt1_n;
      start   <= start_n;
      rw      <= rw_n;
      opcode  <= opcode_n;
      done0   <= done0_n;
      done1   <= done1_n;
      timeout <= timeout_n;
      rdata   <= rdata_n;
      last    <= last_n;
    end
  end

  assign o_gnt0    = gnt0;
  assign o_gnt1    = gnt1;
  assign o_done0   = done0;
  assign o_done1   = done1;
  assign o_rdata   = rdata;
  assign o_timeout = timeout;
  assign o_start   = start;
  assign o_rw      = rw;
  assign o_opcode  = opcode;

endmodule

`default_nettype wire
